// File: rtl/apb_master_pkg.sv
// ============================================================================
// Module      : apb_master_pkg
// Description : Shared types for the APB3 requester: FSM states, command and
//               response records, and a small state helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package apb_master_pkg;

  localparam int APB_DATA_W = 32;
  localparam int APB_ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_t;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_cmd_t;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  error;
  } apb_rsp_t;

  function automatic logic is_busy(input apb_state_t s);
    return s != IDLE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/apb3_master_watchdog.sv
// ============================================================================
// Module      : apb3_master_watchdog
// Description : Counts ACCESS cycles spent with PREADY low and flags expiry
//               on the edge where the count would reach TIMEOUT_CYCLES.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb3_master_watchdog #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic ready,
  output logic expired
);

  localparam int              CW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]   C_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic          r_armed;
  logic [CW-1:0] r_count;

  // A ready on the expiry edge masks the timeout so normal completion wins.
  assign expired = r_armed && !ready && (r_count == C_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_armed <= 1'b0;
      r_count <= '0;
    end else if (start) begin
      r_armed <= 1'b1;
      r_count <= '0;
    end else if (r_armed) begin
      if (ready || expired) begin
        r_armed <= 1'b0;
      end else begin
        r_count <= r_count + CW'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/apb3_master.sv
// ============================================================================
// Module      : apb3_master
// Description : APB3 requester turning a valid/ready command stream into
//               SETUP/ACCESS transfers, one outstanding at a time. Optional
//               ACCESS watchdog enabled by APB3_MASTER_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb3_master
  import apb_master_pkg::*;
#(
  parameter int N_BIT_DATA     = 32,
  parameter int N_BIT_ADDRESS  = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     PCLK,
  input  logic                     PRESET,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [N_BIT_ADDRESS-1:0] cmd_addr,
  input  logic [N_BIT_DATA-1:0]    cmd_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [N_BIT_DATA-1:0]    rsp_rdata,
  output logic                     rsp_error,
  output logic                     PSEL,
  output logic                     PENABLE,
  output logic                     PWRITE,
  output logic [N_BIT_ADDRESS-1:0] PADDR,
  output logic [N_BIT_DATA-1:0]    PWDATA,
  input  logic [N_BIT_DATA-1:0]    PRDATA,
  input  logic                     PREADY,
  input  logic                     PSLVERR
);

  apb_state_t r_state;
  logic       w_accept;
  logic       w_expired;

  assign cmd_ready = !is_busy(r_state) && !PRESET;
  assign w_accept  = cmd_valid && cmd_ready;

`ifdef APB3_MASTER_TIMEOUT_EN
  apb3_master_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (PCLK),
    .rst     (PRESET),
    .start   (r_state == SETUP),
    .ready   (PREADY),
    .expired (w_expired)
  );
`else
  assign w_expired = 1'b0;
`endif

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state   <= IDLE;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            PADDR   <= cmd_addr;
            PWRITE  <= cmd_write;
            // Reads leave PWDATA untouched so the bus does not toggle needlessly.
            if (cmd_write) PWDATA <= cmd_wdata;
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
            r_state <= SETUP;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          r_state <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) begin
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_rdata <= PWRITE ? '0 : PRDATA;
            rsp_error <= PSLVERR;
            rsp_valid <= 1'b1;
            r_state   <= RESP;
          end else if (w_expired) begin
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_rdata <= '0;
            rsp_error <= 1'b1;
            rsp_valid <= 1'b1;
            r_state   <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
